// File: rtl/vector_mem_bridge.sv
// Bridges 128-bit vector loads/stores onto a single-port 32-bit RAM as four beats.
// Busy covers the whole transfer; all outputs are registered.
module vector_mem_bridge #(
    parameter int ADDR_W = 10,
    parameter int WORD_W = 32,
    parameter int BEATS  = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    input  logic                req_we,
    input  logic [31:0]         req_addr,
    input  logic [127:0]        data_b,
    output logic                busy,
    output logic [127:0]        q_b,
    output logic                q_valid,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [WORD_W-1:0]   mem_wdata,
    output logic                mem_we,
    input  logic [WORD_W-1:0]   mem_rdata
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] WR      = 2'd1;
    localparam logic [1:0] RD      = 2'd2;
    localparam logic [1:0] RD_LAST = 2'd3;
    localparam logic [1:0] LAST_BEAT = 2'(BEATS - 1);

    logic [1:0]        state_q, state_d;
    logic [1:0]        beat_q, beat_d;
    logic              busy_q, busy_d;
    logic [127:0]      q_b_q, q_b_d;
    logic              q_valid_q, q_valid_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [WORD_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              mem_we_q, mem_we_d;
    logic [127:0]      data_q, data_d;
    logic [95:0]       asm_q, asm_d;

    logic [ADDR_W-1:0] wbase;
    logic [1:0]        beat_nxt;
    logic              unused_addr_bits;

    // Offset bits and bits above the RAM are dropped, so addresses wrap.
    assign wbase            = {req_addr[ADDR_W+1:4], 2'b00};
    assign beat_nxt         = beat_q + 2'd1;
    assign unused_addr_bits = ^{req_addr[31:ADDR_W+2], req_addr[3:0]};

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        busy_d      = busy_q;
        q_b_d       = q_b_q;
        q_valid_d   = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;
        data_d      = data_q;
        asm_d       = asm_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    data_d     = data_b;
                    beat_d     = 2'd0;
                    busy_d     = 1'b1;
                    mem_addr_d = wbase;
                    if (req_we) begin
                        state_d     = WR;
                        mem_we_d    = 1'b1;
                        mem_wdata_d = data_b[WORD_W-1:0];
                    end else begin
                        state_d = RD;
                    end
                end
            end
            WR: begin
                if (beat_q == LAST_BEAT) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    beat_d  = 2'd0;
                end else begin
                    beat_d      = beat_nxt;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = mem_addr_q + 1'b1;
                    mem_wdata_d = data_q[WORD_W*int'(beat_nxt) +: WORD_W];
                end
            end
            RD: begin
                // Read data trails the address by one cycle, so beat k captures word k-1.
                case (beat_q)
                    2'd1:    asm_d[31:0]  = mem_rdata;
                    2'd2:    asm_d[63:32] = mem_rdata;
                    2'd3:    asm_d[95:64] = mem_rdata;
                    default: ;
                endcase
                if (beat_q == LAST_BEAT) begin
                    state_d = RD_LAST;
                end else begin
                    beat_d     = beat_nxt;
                    mem_addr_d = mem_addr_q + 1'b1;
                end
            end
            default: begin
                q_b_d     = {mem_rdata, asm_q};
                q_valid_d = 1'b1;
                busy_d    = 1'b0;
                beat_d    = 2'd0;
                state_d   = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            beat_q      <= 2'd0;
            busy_q      <= 1'b0;
            q_b_q       <= '0;
            q_valid_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            busy_q      <= busy_d;
            q_b_q       <= q_b_d;
            q_valid_q   <= q_valid_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
        end
    end

    always_ff @(posedge clk) begin
        data_q <= data_d;
        asm_q  <= asm_d;
    end

    assign busy      = busy_q;
    assign q_b       = q_b_q;
    assign q_valid   = q_valid_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_we    = mem_we_q;

endmodule

// File: tb/tb_vector_mem_bridge.sv
// Directed bench for vector_mem_bridge with a 1-cycle-latency RAM model.
module tb_vector_mem_bridge;

    logic         clk = 1'b0;
    logic         reset;
    logic         req_valid;
    logic         req_we;
    logic [31:0]  req_addr;
    logic [127:0] data_b;
    logic         busy;
    logic [127:0] q_b;
    logic         q_valid;
    logic [9:0]   mem_addr;
    logic [31:0]  mem_wdata;
    logic         mem_we;
    logic [31:0]  mem_rdata;

    logic [31:0]  ram [0:1023];

    int vectors = 0;
    int errs    = 0;
    int cnt;

    localparam logic [127:0] D1 = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
    localparam logic [127:0] DX = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
    localparam logic [127:0] D2 = 128'h11111111_22222222_33333333_44444444;
    localparam logic [127:0] D3 = 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0;
    localparam logic [127:0] D4 = 128'h4444DDDD_3333CCCC_2222BBBB_1111AAAA;
    localparam logic [127:0] D5 = 128'h55550003_55550002_55550001_55550000;

    vector_mem_bridge #(.ADDR_W(10), .WORD_W(32), .BEATS(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .data_b    (data_b),
        .busy      (busy),
        .q_b       (q_b),
        .q_valid   (q_valid),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic we, input logic [31:0] addr, input logic [127:0] d);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        data_b    = d;
    endtask

    initial begin
        reset = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; data_b = '0;
        tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_qvalid", q_valid, 0);
        chk("rst_qb", q_b, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        reset = 1'b1;
        tick();

        // store 0x40, data_b changed right after acceptance
        issue(1'b1, 32'h40, D1);
        tick();
        req_valid = 1'b0; data_b = DX;
        for (int k = 0; k < 4; k++) begin
            chk("st_we", mem_we, 1);
            chk("st_busy", busy, 1);
            chk("st_addr", mem_addr, 16 + k);
            chk("st_wdata", mem_wdata, D1[32*k +: 32]);
            tick();
        end
        chk("st_end_busy", busy, 0);
        chk("st_end_we", mem_we, 0);

        // load with offset bits set
        issue(1'b0, 32'h4B, DX);
        tick();
        req_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("ld_we", mem_we, 0);
            chk("ld_addr", mem_addr, 16 + k);
            tick();
        end
        chk("ld_t5_busy", busy, 1);
        chk("ld_t5_qv", q_valid, 0);
        tick();
        chk("ld_t6_qv", q_valid, 1);
        chk("ld_t6_qb", q_b, D1);
        chk("ld_t6_busy", busy, 0);
        tick();
        chk("ld_t7_qv", q_valid, 0);
        chk("ld_t7_qb", q_b, D1);

        // back-to-back stores, req_valid held
        issue(1'b1, 32'h00, D2);
        cnt = 0;
        for (int c = 1; c <= 15; c++) begin
            tick();
            if (mem_we) cnt++;
            if (c == 1)  begin chk("b2b_a0", mem_addr, 0); req_addr = 32'h10; end
            if (c == 5)  chk("b2b_busy5", busy, 0);
            if (c == 6)  begin chk("b2b_a1", mem_addr, 4); req_addr = 32'h00; end
            if (c == 10) chk("b2b_busy10", busy, 0);
            if (c == 11) begin chk("b2b_a2", mem_addr, 0); req_valid = 1'b0; end
        end
        chk("b2b_we_cnt", cnt, 12);
        chk("b2b_busy_end", busy, 0);
        chk("b2b_qb_kept", q_b, D1);
        chk("b2b_ram4", ram[4], 32'h44444444);

        // busy rejection on a load to 0x80
        issue(1'b1, 32'h80, D3);
        tick();
        req_valid = 1'b0;
        tick(); tick(); tick(); tick();
        issue(1'b0, 32'h80, DX);
        cnt = 0;
        for (int c = 1; c <= 9; c++) begin
            tick();
            if (c <= 4) chk("rej_addr", mem_addr, 32 + c - 1);
            if (q_valid) cnt++;
            if (c == 6) begin
                chk("rej_qb", q_b, D3);
                req_valid = 1'b0;
            end
        end
        chk("rej_pulses", cnt, 1);
        chk("rej_busy", busy, 0);

        // address wrap: 0x1000 maps to word 0
        issue(1'b1, 32'h1000, D4);
        tick();
        req_valid = 1'b0;
        chk("wrap_addr", mem_addr, 0);
        tick(); tick(); tick(); tick();
        issue(1'b0, 32'h0, DX);
        tick();
        req_valid = 1'b0;
        for (int c = 0; c < 5; c++) tick();
        chk("wrap_qv", q_valid, 1);
        chk("wrap_qb", q_b, D4);

        // reset in the middle of a store to word 128
        issue(1'b1, 32'h200, D5);
        tick();
        req_valid = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("rms_we", mem_we, 0);
        chk("rms_busy", busy, 0);
        chk("rms_qb", q_b, 0);
        cnt = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (mem_we) cnt++;
        end
        chk("rms_no_we", cnt, 0);
        chk("rms_ram128", ram[128], 32'h55550000);
        chk("rms_ram129", ram[129], 32'h55550001);
        chk("rms_ram130", (ram[130] === 32'h55550002), 0);
        chk("rms_ram131", (ram[131] === 32'h55550003), 0);

        // reset in the middle of a load
        issue(1'b0, 32'h40, DX);
        tick();
        req_valid = 1'b0;
        tick(); tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        cnt = 0;
        for (int c = 0; c < 8; c++) begin
            if (q_valid) cnt++;
            tick();
        end
        chk("rml_no_qv", cnt, 0);
        chk("rml_busy", busy, 0);
        chk("rml_qb", q_b, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule

// File: doc/vector_mem_bridge.md
Name: vector_mem_bridge

Overview:
- Sits directly downstream of the processor datapath's vector port.
- Consumes each 128-bit vector store (data_b) and each vector load request, and produces the 128-bit load result (q_b) fed back to vector writeback.
- Serialises each 16-byte vector into WORD_W-bit beats on a single-port, word-wide data RAM that also holds the FIR audio samples and coefficients.
- Asserts busy so hazard logic can stall fetch/decode while a transfer is in flight.

Parameters:
- ADDR_W, 10: word-address width of the attached RAM.
- WORD_W, 32: RAM data width; fixed at 32.
- BEATS, 4: words per vector (128/WORD_W); fixed at 4.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-low reset.
- req_valid  input  1  vector memory request this cycle.
- req_we  input  1  1 = vector store, 0 = vector load.
- req_addr  input  32  byte address (ALUResultE); bits [3:0] ignored.
- data_b  input  128  store data; byte lane i = data_b[8i+7:8i].
- busy  output  1  transfer in progress; requests ignored while high.
- q_b  output  128  assembled load result.
- q_valid  output  1  one-cycle pulse, q_b updated this cycle.
- mem_addr  output  ADDR_W  RAM word address.
- mem_wdata  output  32  RAM write data.
- mem_we  output  1  RAM write enable.
- mem_rdata  input  32  RAM read data; 1-cycle registered read latency.

Behaviour:
- Reset (reset==0 at a clk edge):
  - state=IDLE, busy=0, q_valid=0, q_b=0, mem_we=0, mem_addr=0, mem_wdata=0, beat counter=0.
  - Takes priority over everything, including mid-transfer: any partial write stops immediately, with no further mem_we.
  - A partial read is discarded and no q_valid pulse is produced.
- All outputs are registered; no combinational path from inputs to outputs.
- Base word address: wbase = {req_addr[ADDR_W+1:4], 2'b00}. Upper address bits are truncated, so the address space wraps modulo 2^ADDR_W words.
- Acceptance:
  - A request is accepted in cycle t when state==IDLE and req_valid==1.
  - data_b, req_we and wbase are latched at t, so the upstream may change them from t+1.
  - busy=1 from t+1 until the last cycle of the transfer.
  - req_valid while busy==1 is ignored; it is neither queued nor merged.
- STORE, states IDLE -> WR -> IDLE:
  - Cycles t+1..t+4: mem_we=1, mem_addr=wbase+k, mem_wdata=latched[32k+31:32k] for k=0..3.
  - busy=1 on t+1..t+4. At t+5: busy=0, mem_we=0, state=IDLE.
  - A new request may be accepted at t+5.
- LOAD, states IDLE -> RD -> RD_LAST -> IDLE:
  - Cycles t+1..t+4: mem_we=0, mem_addr=wbase+k.
  - mem_rdata for beat k is valid at t+2+k and is captured into lane word k of an assembly register.
  - RD_LAST (t+5) captures the final word.
  - At t+6: q_b = {w3,w2,w1,w0}, q_valid=1 for exactly one cycle, busy=0.
  - busy=1 on t+1..t+5.
  - q_b holds its value until the next completed load; stores never alter q_b.
- Beat counter is 2 bits and wraps 3->0 only at end of transfer.
- mem_we is never asserted in IDLE, RD or RD_LAST.
- A request arriving in the same cycle as the one where busy falls is accepted, since state==IDLE.
- Hazard interface: the top level ORs busy into StallF/StallD. Upstream holds req_valid until it observes busy rise.

Test Plan:
- Reset mid-store: accept store, pull reset low at t+2 -> at t+3 mem_we=0, busy=0, q_b=0, and only beats 0 and 1 were written.
- Store then load:
  - Store req_addr=0x40, data_b=0x0F0E0D0C_0B0A0908_07060504_03020100 -> writes words 16..19 = 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C on t+1..t+4.
  - Load 0x40 -> q_b equals the stored value with q_valid pulsed once at t+6.
- Alignment and wrap:
  - req_addr=0x4B -> same words as 0x40, offset bits ignored.
  - With ADDR_W=10, req_addr=0x1000 -> wbase=0 (wrap).
- Busy rejection: assert req_valid on every cycle of a load to 0x80 -> only the first is accepted, one q_valid pulse, mem_addr sequence 32,33,34,35.
- Back-to-back: hold req_valid with req_we=1, alternating address 0x00/0x10 -> accepted at t, t+5, t+10, with mem_we high exactly 4 of every 5 cycles.
- Data latching: change data_b at t+1 during a store -> RAM receives the value sampled at t.
